// File: rtl/router_pkg.sv
// Shared router definitions: one-hot FSM encoding,
// default port count and address-width helper.
package router_pkg;

  localparam int NUM_PORTS_DEF = 3;
  localparam int NUM_ST = 9;

  localparam int ST_DA   = 0;
  localparam int ST_LFD  = 1;
  localparam int ST_LD   = 2;
  localparam int ST_LP   = 3;
  localparam int ST_FFS  = 4;
  localparam int ST_LAF  = 5;
  localparam int ST_WTE  = 6;
  localparam int ST_CPE  = 7;
  localparam int ST_DROP = 8;

  typedef enum logic [NUM_ST-1:0] {
    S_DA   = 9'b000000001,
    S_LFD  = 9'b000000010,
    S_LD   = 9'b000000100,
    S_LP   = 9'b000001000,
    S_FFS  = 9'b000010000,
    S_LAF  = 9'b000100000,
    S_WTE  = 9'b001000000,
    S_CPE  = 9'b010000000,
    S_DROP = 9'b100000000
  } state_e;

  // Never returns 0, even for a single-bit address.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Saturating wait counter with an expire compare.
// A zero limit disables expiry.
module router_wait_timer #(
  parameter int TMO_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             run,
  input  logic [TMO_W-1:0] limit,
  output logic             expire
);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run) begin
      if (&cnt_q) cnt_d = cnt_q;
      else        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  always_comb begin
    expire = 1'b0;
    if (run && (limit != '0))
      expire = (cnt_q == (limit - 1'b1));
  end

endmodule

// File: rtl/router_fsm_np.sv
// Router control FSM: header decode, payload load,
// full stalls, parity and drop of bad/stale packets.
module router_fsm_np
  import router_pkg::*;
#(
  parameter int NUM_PORTS    = NUM_PORTS_DEF,
  parameter int ADDR_W       = addr_w(NUM_PORTS),
  parameter int WAIT_TIMEOUT = 0,
  parameter int TMO_W        = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 low_pkt_valid,
  input  logic                 parity_done,
  output logic                 busy,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 write_enb_reg,
  output logic                 rst_int_reg,
  output logic                 drop_state,
  output logic                 timeout_err,
  output logic [ADDR_W-1:0]    addr_o
);

  localparam int SPAN = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NP_L =
    (ADDR_W+1)'(NUM_PORTS);
  localparam logic [TMO_W-1:0] LIMIT =
    TMO_W'(WAIT_TIMEOUT);

  state_e state_q;
  state_e state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  logic [SPAN-1:0] empty_pad;
  logic [SPAN-1:0] srst_pad;
  logic            hdr_oor;
  logic            in_wte;
  logic            expire;

  // Pad to the full address span so out-of-range
  // addresses index a defined zero bit.
  always_comb begin
    empty_pad = '0;
    srst_pad  = '0;
    empty_pad[NUM_PORTS-1:0] = fifo_empty;
    srst_pad[NUM_PORTS-1:0]  = soft_reset;
  end

  assign hdr_oor = ({1'b0, data_in} >= NP_L);
  assign in_wte  = state_q[ST_WTE];

  router_wait_timer #(
    .TMO_W (TMO_W)
  ) u_timer (
    .clock  (clock),
    .resetn (resetn),
    .run    (in_wte),
    .limit  (LIMIT),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (1'b1)
      state_q[ST_DA]: begin
        if (pkt_valid) begin
          addr_d = data_in;
          if (hdr_oor)
            state_d = S_DROP;
          else if (empty_pad[data_in])
            state_d = S_LFD;
          else
            state_d = S_WTE;
        end
      end
      state_q[ST_LFD]: state_d = S_LD;
      state_q[ST_LD]: begin
        if (fifo_full)       state_d = S_FFS;
        else if (!pkt_valid) state_d = S_LP;
      end
      state_q[ST_LP]: state_d = S_CPE;
      state_q[ST_FFS]: begin
        if (!fifo_full) state_d = S_LAF;
      end
      state_q[ST_LAF]: begin
        if (parity_done)        state_d = S_DA;
        else if (low_pkt_valid) state_d = S_LP;
        else                    state_d = S_LD;
      end
      state_q[ST_CPE]: begin
        if (fifo_full) state_d = S_FFS;
        else           state_d = S_DA;
      end
      state_q[ST_WTE]: begin
        if (empty_pad[addr_q]) state_d = S_LFD;
        else if (expire)       state_d = S_DROP;
      end
      state_q[ST_DROP]: begin
        if (!pkt_valid) state_d = S_DA;
      end
      default: state_d = S_DA;
    endcase
    // Soft reset of the active port beats any transition.
    if (!state_q[ST_DA] && srst_pad[addr_q])
      state_d = S_DA;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_DA;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign busy = state_q[ST_LFD] | state_q[ST_LP]
              | state_q[ST_FFS] | state_q[ST_LAF]
              | state_q[ST_WTE] | state_q[ST_CPE];
  assign detect_add    = state_q[ST_DA];
  assign lfd_state     = state_q[ST_LFD];
  assign ld_state      = state_q[ST_LD];
  assign laf_state     = state_q[ST_LAF];
  assign full_state    = state_q[ST_FFS];
  assign write_enb_reg = state_q[ST_LD]
                       | state_q[ST_LAF]
                       | state_q[ST_LP];
  assign rst_int_reg   = state_q[ST_CPE];
  assign drop_state    = state_q[ST_DROP];
  assign timeout_err   = expire & ~empty_pad[addr_q];
  assign addr_o        = addr_q;

endmodule

// File: doc/router_fsm_np.md
Name: router_fsm_np

Overview:
- Parametrised next-generation router control FSM. Sequences header decode, payload load, FIFO-full stalls, parity load/check and soft-reset recovery for NUM_PORTS destination FIFOs; the current controller is fixed at 3.
- New behaviour:
  - Out-of-range header addresses are dropped.
  - A configurable timeout on waiting for the destination FIFO to empty, after which the packet is dropped and an error flagged.
- Sits between the register block (data path, parity) and the per-port FIFOs/synchroniser.

Parameters:
- NUM_PORTS, 3, number of destination FIFOs (2..8).
- ADDR_W, $clog2(NUM_PORTS) (min 1), header address field width = data_in width.
- WAIT_TIMEOUT, 0, cycles allowed in WAIT_TILL_EMPTY before drop; 0 disables the timeout.
- TMO_W, 16, width of the wait counter; WAIT_TIMEOUT < 2**TMO_W.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  reset, synchronous, active-low
- pkt_valid  in  1  source packet valid
- data_in  in  ADDR_W  header address bits (data[ADDR_W-1:0])
- fifo_full  in  1  full flag of selected FIFO
- fifo_empty  in  NUM_PORTS  per-port empty flags
- soft_reset  in  NUM_PORTS  per-port soft reset from synchroniser
- low_pkt_valid  in  1  registered pkt_valid-low indicator
- parity_done  in  1  parity byte captured
- busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg  out  1 each  Moore state decodes (below)
- drop_state  out  1  packet being discarded
- timeout_err  out  1  one-cycle pulse on wait timeout
- addr_o  out  ADDR_W  latched destination address

Behaviour:
- One-hot states:
  - DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), LOAD_PARITY (LP)
  - FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), WAIT_TILL_EMPTY (WTE)
  - CHECK_PARITY_ERROR (CPE), DROP_PACKET (DROP)
- Reset (resetn=0 at clock edge): state=DA, addr_o=0, wait counter=0. All outputs derive from the state, so after reset detect_add=1 and every other output is 0.
- addr_o latches data_in only when state==DA && pkt_valid. It holds otherwise.
- State register priority:
  1. resetn low.
  2. soft_reset[addr_o] high while state!=DA: go to DA.
  3. Next state.
- Transitions:
  - DA:
    - pkt_valid && data_in>=NUM_PORTS -> DROP.
    - pkt_valid && fifo_empty[data_in] -> LFD.
    - pkt_valid, not empty -> WTE.
    - Else stay in DA.
  - LFD -> LD.
  - LD: fifo_full -> FFS; else !pkt_valid -> LP; else stay in LD.
  - LP -> CPE.
  - FFS: fifo_full -> FFS; else -> LAF.
  - LAF: parity_done -> DA; else low_pkt_valid -> LP; else -> LD.
  - CPE: fifo_full -> FFS; else -> DA.
  - WTE:
    - fifo_empty[addr_o] -> LFD.
    - Else WAIT_TIMEOUT!=0 && cnt==WAIT_TIMEOUT-1 -> DROP.
    - Else stay in WTE.
  - DROP: !pkt_valid -> DA, so the parity byte presented with pkt_valid low is discarded. Else stay in DROP.
- Wait counter:
  - Clears on every cycle the state is not WTE.
  - Increments each WTE cycle.
  - Saturates at all-ones and never wraps.
- timeout_err = (state==WTE) && WAIT_TIMEOUT!=0 && cnt==WAIT_TIMEOUT-1 && !fifo_empty[addr_o]. Combinational, exactly one cycle per timeout event.
- Output decodes:
  - busy = LFD | LP | FFS | LAF | WTE | CPE. Busy is 0 in DA, LD and DROP; DROP lets the source stream the packet out.
  - detect_add = DA
  - lfd_state = LFD
  - ld_state = LD
  - laf_state = LAF
  - full_state = FFS
  - write_enb_reg = LD | LAF | LP. It is never asserted in DROP.
  - rst_int_reg = CPE
  - drop_state = DROP
- Simultaneous events:
  - In WTE, if the FIFO empties on the timeout cycle, the empty flag wins: go to LFD, no timeout_err.
  - Soft reset outranks every transition, including DROP and WTE.
  - Soft reset of a port other than addr_o has no effect.
- resetn low mid-packet aborts at the next edge. The FSM does not resume.

Decomposition:
- Shared package router_pkg:
  - state encoding localparams (one-hot, 9 bits), shared with the register block and the SVA bind.
  - NUM_PORTS default.
  - clog2-safe ADDR_W helper function.
- Sub-module router_wait_timer: wait counter plus the compare producing the expire flag. Inputs: clock, resetn, run (state==WTE), limit. It has its own saturation logic and can be reused for the synchroniser's 30-cycle read timeout.

Test Plan:
- NUM_PORTS=4, WAIT_TIMEOUT=0. Header addr=3 with fifo_empty=4'b1111, then 4 payload cycles, then pkt_valid low -> states DA, LFD, LD x4, LP, CPE, DA; write_enb_reg high 5 cycles; addr_o=3.
- Header addr=1 with fifo_empty[1]=0 for 6 cycles -> WTE with busy=1 for 6 cycles, then LFD on the cycle after empty rises.
- WAIT_TIMEOUT=8 with fifo_empty[2] held 0 -> timeout_err high in exactly the 8th WTE cycle, then DROP (busy=0, write_enb_reg=0). pkt_valid low -> DA.
- NUM_PORTS=3, header data_in=3 -> DROP directly, no LFD, write_enb_reg never asserted; returns to DA when pkt_valid falls.
- In LD, fifo_full=1 for 3 cycles -> FFS x3, then LAF. With low_pkt_valid=1 -> LP, CPE. soft_reset[addr_o] pulsed in FFS -> DA next cycle; soft_reset on another port -> no change.
- resetn=0 during LAF -> DA, addr_o=0, counter=0, all outputs except detect_add low on the next cycle.
